// File: rtl/pipe_slice.sv
// Configurable valid/ready pipeline slice: bypass, forward, backward (skid) or full register.
// Optional synchronous flush input enabled by defining PIPE_SLICE_FLUSH_EN.
module pipe_slice #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MODE       = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] tdata_i,
  input  logic                  tvalid_i,
  output logic                  tready_i,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tvalid_o,
  input  logic                  tready_o,
  output logic [1:0]            level
`ifdef PIPE_SLICE_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  logic w_flush;
`ifdef PIPE_SLICE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  if (DATA_WIDTH < 1 || DATA_WIDTH > 1024) begin : g_bad_width
    $error("pipe_slice: DATA_WIDTH %0d outside 1..1024", DATA_WIDTH);
  end

  if (MODE == 0) begin : g_bypass
    logic w_unused_flush;
    assign w_unused_flush = w_flush;
    assign tdata_o  = tdata_i;
    assign tvalid_o = tvalid_i;
    assign tready_i = tready_o;
    assign level    = 2'd0;

  end else if (MODE == 1) begin : g_forward
    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_ready;
    logic                  w_push;

    assign w_ready = tready_o | ~r_full;
    assign w_push  = tvalid_i & w_ready;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_full <= 1'b0;
        r_data <= '0;
      end else if (w_flush) begin
        r_full <= 1'b0;
      end else if (w_push) begin
        r_full <= 1'b1;
        r_data <= tdata_i;
      end else if (tready_o) begin
        r_full <= 1'b0;
      end
    end

    assign tdata_o  = r_data;
    assign tvalid_o = r_full;
    assign tready_i = w_ready;
    assign level    = {1'b0, r_full};

  end else if (MODE == 2) begin : g_backward
    logic                  r_skid_full;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  w_capture;

    // Park the beat only when it was accepted upstream but stalled downstream.
    assign w_capture = tvalid_i & ~r_skid_full & ~tready_o;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_skid_full <= 1'b0;
        r_skid_data <= '0;
      end else if (w_flush) begin
        r_skid_full <= 1'b0;
      end else if (w_capture) begin
        r_skid_full <= 1'b1;
        r_skid_data <= tdata_i;
      end else if (r_skid_full && tready_o) begin
        r_skid_full <= 1'b0;
      end
    end

    assign tready_i = ~r_skid_full;
    assign tvalid_o = tvalid_i | r_skid_full;
    assign tdata_o  = r_skid_full ? r_skid_data : tdata_i;
    assign level    = {1'b0, r_skid_full};

  end else if (MODE == 3) begin : g_full
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;
    logic                  w_push;
    logic                  w_pop;

    assign w_push = tvalid_i & (r_count != 2'd2);
    assign w_pop  = tready_o & (r_count != 2'd0);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < 2; i++) r_mem[i] <= '0;
        r_wptr  <= 1'b0;
        r_rptr  <= 1'b0;
        r_count <= 2'd0;
      end else if (w_flush) begin
        r_wptr  <= 1'b0;
        r_rptr  <= 1'b0;
        r_count <= 2'd0;
      end else begin
        if (w_push) begin
          r_mem[r_wptr] <= tdata_i;
          r_wptr        <= ~r_wptr;
        end
        if (w_pop) r_rptr <= ~r_rptr;
        if (w_push && !w_pop)      r_count <= r_count + 2'd1;
        else if (!w_push && w_pop) r_count <= r_count - 2'd1;
      end
    end

    assign tdata_o  = r_mem[r_rptr];
    assign tvalid_o = (r_count != 2'd0);
    assign tready_i = (r_count != 2'd2);
    assign level    = r_count;

  end else begin : g_bad_mode
    $error("pipe_slice: illegal MODE %0d (legal 0..3)", MODE);
    logic w_unused_bad;
    assign w_unused_bad = w_flush | clk | rstn | tvalid_i | tready_o | (|tdata_i);
    assign tdata_o  = '0;
    assign tvalid_o = 1'b0;
    assign tready_i = 1'b0;
    assign level    = 2'd0;
  end

endmodule
